sbox_mlane_unit: RTL and testbench
==================================

Name: sbox_mlane_unit

Overview:
- Parametrised, multi-lane AES byte-substitution engine; a successor to the single-byte registered inverse LUT.
- Accepts a word of LANES bytes plus a direction bit (forward SubBytes or InvSubBytes) over a valid/ready handshake.
- Substitutes the bytes through PORTS time-multiplexed LUT instances, LANES/PORTS beats per word, then returns the word over a second valid/ready handshake.
- Shared by the encryption datapath, decryption datapath and key expansion (LANES=4 for RotWord/SubWord, 16 for full state).

Parameters:
- LANES, 16, bytes per input/output word; must be ≥1.
- PORTS, 4, LUT instances used per beat; must divide LANES; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  unit can accept a word
- in_mode  in  1  0 = forward S-box, 1 = inverse S-box
- in_data  in  8*LANES  byte i = in_data[8i+7:8i]
- out_valid  out  1  result word present
- out_ready  in  1  consumer accepts result
- out_data  out  8*LANES  substituted word, same byte ordering
- out_mode  out  1  mode the result was computed with
- busy  out  1  high in BUSY state

Behaviour:
- Reset is asynchronous on rst_n low:
  - state=IDLE, beat counter=0, out_valid=0, out_data=0, out_mode=0, busy=0.
  - Internal captured word and mode are cleared.
  - A reset mid-word discards that word; no partial output appears.
- The FSM has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data and in_mode, set beat=0, go to BUSY.
  - BUSY: in_ready=0, busy=1.
    - Each cycle, bytes beat*PORTS .. beat*PORTS+PORTS-1 pass through PORTS lookups and are written into the result register.
    - beat increments each cycle.
    - At beat=S-1 (S=LANES/PORTS), go to DONE.
  - DONE: out_valid=1, and out_data/out_mode stay stable until the handshake.
    - On out_ready: if in_valid, capture the new word and go straight to BUSY (back-to-back); otherwise go to IDLE.
    - in_ready = out_ready in DONE (combinational). This is the only combinational input-to-output path.
- Latency: out_valid rises S cycles after the acceptance edge.
  - Throughput is one word per S+1 cycles under continuous ready.
  - S=1 is legal: BUSY lasts one cycle.
- Lookups and direction:
  - Lookups are combinational inside the LUT sub-module; the result register is the only storage.
  - Byte mux selection uses the beat counter.
  - in_mode and in_data changes outside the acceptance cycle are ignored; the mode is frozen per word.
- out_data bytes not yet written in a word retain previous values internally. They are never visible, because out_valid is only asserted once all S beats are complete.
- out_valid is never dropped without an out_ready handshake.
- The beat counter is $clog2(S) bits, minimum 1. It wraps to 0 on leaving BUSY.

Optional Feature:
- Macro: SBOX_ROUNDTRIP_CHECK_EN.
- When defined:
  - Each lookup port also applies the opposite-direction LUT to its result and compares it with the source byte.
  - Any mismatch during the word sets a sticky per-word flag.
  - New port out_err (out, 1) is valid with out_valid and is cleared on each new acceptance and on reset.
  - Intended for ROM fault detection.
- When not defined: no out_err port and no second LUT; area is halved.

Decomposition:
- Package sbox_pkg holds:
  - the 256-entry forward and inverse S-box constant arrays (localparam byte arrays)
  - the mode encoding constants SBOX_FWD=1'b0 and SBOX_INV=1'b1
  - the FSM state enum (IDLE, BUSY, DONE)
- One sub-module, sbox_lut: a combinational byte-in/byte-out lookup with a mode input, instantiated PORTS times (2×PORTS under SBOX_ROUNDTRIP_CHECK_EN).

Test Plan:
- Reset, then the forward word: LANES=16, PORTS=4, mode=0, bytes 0..3 = 19,3D,E3,BE, rest 00. Required: out_valid exactly 4 cycles after acceptance; out bytes D4,27,11,AE, rest 63; out_mode=0.
- Inverse word: mode=1, bytes 0..3 = D4,27,11,AE, rest 00. Required: bytes 19,3D,E3,BE, rest 52.
- Backpressure: hold out_ready=0 for 10 cycles. Required: out_valid and out_data stable and in_ready=0. Then raise out_ready with in_valid=1 and a new word: that word is accepted in the same cycle and its result appears 4 cycles later.
- Reset mid-BUSY (beat=2): assert rst_n=0 asynchronously between edges. Required: out_valid=0 and busy=0 immediately; after release, a fresh word with mode=0 and all bytes 53 returns all bytes ED.
- Parameter sweep (LANES,PORTS) = (4,4), (4,1), (16,16): exhaustive fwd(inv(x))=x over x=00..FF. Required: latency = LANES/PORTS cycles.
- With SBOX_ROUNDTRIP_CHECK_EN, force the forward ROM entry 0x00 to 0x64 and send mode=0 with byte 0 = 00. Required: out_err=1. A following clean word returns out_err=0.

Source files
------------

// File: rtl/sbox_pkg.sv
// Shared AES S-box constants: forward/inverse byte tables, mode encoding and FSM states.
package sbox_pkg;

  localparam logic SBOX_FWD = 1'b0;
  localparam logic SBOX_INV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } sbox_state_e;

  localparam logic [7:0] SBOX_FWD_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV_TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lut.sv
// Combinational single-byte S-box lookup; mode selects forward or inverse table.
module sbox_lut
  import sbox_pkg::*;
(
  input  logic       mode_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  always_comb begin
    if (mode_i == SBOX_INV) begin
      data_o = SBOX_INV_TABLE[data_i];
    end else begin
      data_o = SBOX_FWD_TABLE[data_i];
    end
  end

endmodule

// File: rtl/sbox_mlane_unit.sv
// Multi-lane AES byte substitution: LANES bytes through PORTS shared LUTs, LANES/PORTS beats.
// Optional SBOX_ROUNDTRIP_CHECK_EN adds an inverse-direction recheck and the out_err port.
module sbox_mlane_unit
  import sbox_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned PORTS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_mode,
`ifdef SBOX_ROUNDTRIP_CHECK_EN
  output logic               out_err,
`endif
  output logic               busy
);

  localparam int unsigned PORTS_SAFE = (PORTS == 0) ? 1 : PORTS;
  localparam bit          CFG_OK     = (LANES >= 1) && (PORTS >= 1) &&
                                       ((LANES % PORTS_SAFE) == 0);
  localparam int unsigned STEPS      = LANES / PORTS_SAFE;
  localparam int unsigned BEAT_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned BEAT_BITS  = 8 * PORTS;

  if (!CFG_OK) begin : g_bad_cfg
    $error("sbox_mlane_unit: PORTS must be >= 1 and divide LANES (>= 1)");
  end

  sbox_state_e         state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [8*LANES-1:0]  data_q, data_d;
  logic [8*LANES-1:0]  res_q, res_d;
  logic                mode_q, mode_d;
  logic [BEAT_BITS-1:0] lut_src;
  logic [BEAT_BITS-1:0] lut_res;
  logic                last_beat;
  logic                accept;

  assign last_beat = (beat_q == BEAT_W'(STEPS - 1));

  // Compare-based mux keeps the select lint-clean for non-power-of-two beat counts.
  always_comb begin
    lut_src = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (beat_q == BEAT_W'(s)) begin
        lut_src = data_q[s*BEAT_BITS +: BEAT_BITS];
      end
    end
  end

`ifdef SBOX_ROUNDTRIP_CHECK_EN
  logic [PORTS-1:0] rt_mismatch;
`endif

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    sbox_lut u_lut (
      .mode_i (mode_q),
      .data_i (lut_src[8*p +: 8]),
      .data_o (lut_res[8*p +: 8])
    );
`ifdef SBOX_ROUNDTRIP_CHECK_EN
    logic [7:0] back;
    sbox_lut u_back (
      .mode_i (~mode_q),
      .data_i (lut_res[8*p +: 8]),
      .data_o (back)
    );
    assign rt_mismatch[p] = (back != lut_src[8*p +: 8]);
`endif
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    data_d    = data_q;
    mode_d    = mode_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      StBusy: begin
        busy = 1'b1;
        for (int s = 0; s < STEPS; s++) begin
          if (beat_q == BEAT_W'(s)) begin
            res_d[s*BEAT_BITS +: BEAT_BITS] = lut_res;
          end
        end
        if (last_beat) begin
          beat_d  = '0;
          state_d = StDone;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          accept = in_valid;
          if (!in_valid) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      data_d  = in_data;
      mode_d  = in_mode;
      beat_d  = '0;
      state_d = StBusy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      data_q  <= '0;
      mode_q  <= SBOX_FWD;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
    end
  end

  assign out_data = res_q;
  assign out_mode = mode_q;

`ifdef SBOX_ROUNDTRIP_CHECK_EN
  logic err_q, err_d;

  // Sticky across the beats of one word, cleared when the next word is taken.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == StBusy) && (|rt_mismatch)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`endif

endmodule

// File: tb/tb_sbox_mlane_unit.sv
// Directed bench for sbox_mlane_unit: main 16x4 instance plus 4x4, 4x1 and 16x16 sweeps.
module tb_sbox_mlane_unit;

  localparam logic [127:0] FWD_IN   = {96'h0, 32'hBEE33D19};
  localparam logic [127:0] FWD_EXP  = {{12{8'h63}}, 32'hAE1127D4};
  localparam logic [127:0] INV_IN   = {96'h0, 32'hAE1127D4};
  localparam logic [127:0] INV_EXP  = {{12{8'h52}}, 32'hBEE33D19};
  localparam logic [127:0] LANE_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] LANE_EXP = 128'h76abd7fe2b670130c56f6bf27b777c63;

  int checks;
  int failures;

  logic clk;
  logic rst_n;

  logic         m_in_valid, m_in_ready, m_in_mode;
  logic [127:0] m_in_data;
  logic         m_out_valid, m_out_ready, m_out_mode, m_busy;
  logic [127:0] m_out_data;
`ifdef SBOX_ROUNDTRIP_CHECK_EN
  logic         m_out_err;
  logic [2:0]   sv_err;
`endif

  logic [2:0]   sv_in_valid, sv_in_ready, sv_out_valid, sv_out_mode, sv_busy;
  logic         sv_in_mode;
  logic         sv_out_ready;
  logic [127:0] sv_in_data;
  logic [31:0]  sv_od0, sv_od1;
  logic [127:0] sv_od2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sbox_mlane_unit #(.LANES(16), .PORTS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_mode   (m_in_mode),
    .in_data   (m_in_data),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_data  (m_out_data),
    .out_mode  (m_out_mode),
`ifdef SBOX_ROUNDTRIP_CHECK_EN
    .out_err   (m_out_err),
`endif
    .busy      (m_busy)
  );

  sbox_mlane_unit #(.LANES(4), .PORTS(4)) u_sw0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sv_in_valid[0]),
    .in_ready  (sv_in_ready[0]),
    .in_mode   (sv_in_mode),
    .in_data   (sv_in_data[31:0]),
    .out_valid (sv_out_valid[0]),
    .out_ready (sv_out_ready),
    .out_data  (sv_od0),
    .out_mode  (sv_out_mode[0]),
`ifdef SBOX_ROUNDTRIP_CHECK_EN
    .out_err   (sv_err[0]),
`endif
    .busy      (sv_busy[0])
  );

  sbox_mlane_unit #(.LANES(4), .PORTS(1)) u_sw1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sv_in_valid[1]),
    .in_ready  (sv_in_ready[1]),
    .in_mode   (sv_in_mode),
    .in_data   (sv_in_data[31:0]),
    .out_valid (sv_out_valid[1]),
    .out_ready (sv_out_ready),
    .out_data  (sv_od1),
    .out_mode  (sv_out_mode[1]),
`ifdef SBOX_ROUNDTRIP_CHECK_EN
    .out_err   (sv_err[1]),
`endif
    .busy      (sv_busy[1])
  );

  sbox_mlane_unit #(.LANES(16), .PORTS(16)) u_sw2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sv_in_valid[2]),
    .in_ready  (sv_in_ready[2]),
    .in_mode   (sv_in_mode),
    .in_data   (sv_in_data),
    .out_valid (sv_out_valid[2]),
    .out_ready (sv_out_ready),
    .out_data  (sv_od2),
    .out_mode  (sv_out_mode[2]),
`ifdef SBOX_ROUNDTRIP_CHECK_EN
    .out_err   (sv_err[2]),
`endif
    .busy      (sv_busy[2])
  );

  function automatic logic [127:0] sv_od(input int k);
    case (k)
      0:       return {96'h0, sv_od0};
      1:       return {96'h0, sv_od1};
      default: return sv_od2;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic m_accept(input logic mode, input logic [127:0] data, output bit ok);
    m_in_mode  = mode;
    m_in_data  = data;
    m_in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    m_in_valid = 1'b0;
  endtask

  task automatic m_wait_valid(output int lat);
    lat = 0;
    while (m_out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic m_drain();
    m_out_ready = 1'b1;
    @(negedge clk);
    m_out_ready = 1'b0;
  endtask

  task automatic sv_run(input int k, input logic mode, input logic [127:0] data,
                        output logic [127:0] res, output int lat);
    bit ok;
    sv_in_mode     = mode;
    sv_in_data     = data;
    sv_in_valid[k] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (sv_in_ready[k] === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    sv_in_valid[k] = 1'b0;
    lat = 0;
    while (sv_out_valid[k] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = sv_od(k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", m_out_valid);
    end
    checks++;
    if (m_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", m_busy);
    end
    checks++;
    if (m_out_data !== 128'h0) begin
      failures++; $display("FAIL reset_out_data got=%h exp=0", m_out_data);
    end
    checks++;
    if (m_out_mode !== 1'b0) begin
      failures++; $display("FAIL reset_out_mode got=%b exp=0", m_out_mode);
    end
    checks++;
    if (m_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", m_in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward_backpressure();
    bit ok;
    int lat;
    bit held_ok;
    m_out_ready = 1'b0;
    m_accept(1'b0, FWD_IN, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL fwd_accept got=0 exp=1");
    end
    m_wait_valid(lat);
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL fwd_latency got=%0d exp=4", lat);
    end
    checks++;
    if (m_out_data !== FWD_EXP) begin
      failures++; $display("FAIL fwd_data got=%h exp=%h", m_out_data, FWD_EXP);
    end
    checks++;
    if (m_out_mode !== 1'b0) begin
      failures++; $display("FAIL fwd_mode got=%b exp=0", m_out_mode);
    end
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_out_valid !== 1'b1 || m_out_data !== FWD_EXP || m_in_ready !== 1'b0) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      failures++;
      $display("FAIL backpressure_hold got valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h",
               m_out_valid, m_in_ready, m_out_data, FWD_EXP);
    end
    m_in_valid  = 1'b1;
    m_in_mode   = 1'b1;
    m_in_data   = INV_IN;
    m_out_ready = 1'b1;
    #1;
    checks++;
    if (m_in_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_in_ready got=%b exp=1", m_in_ready);
    end
    @(negedge clk);
    m_in_valid  = 1'b0;
    m_out_ready = 1'b0;
    checks++;
    if (m_busy !== 1'b1) begin
      failures++; $display("FAIL b2b_busy got=%b exp=1", m_busy);
    end
    m_wait_valid(lat);
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL inv_latency got=%0d exp=4", lat);
    end
    checks++;
    if (m_out_data !== INV_EXP) begin
      failures++; $display("FAIL inv_data got=%h exp=%h", m_out_data, INV_EXP);
    end
    checks++;
    if (m_out_mode !== 1'b1) begin
      failures++; $display("FAIL inv_mode got=%b exp=1", m_out_mode);
    end
    m_drain();
  endtask

  task automatic test_lane_map();
    bit ok;
    int lat;
    m_accept(1'b0, LANE_IN, ok);
    m_in_mode = 1'b1;
    m_in_data = {128{1'b1}};
    m_wait_valid(lat);
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL lane_latency got=%0d exp=4", lat);
    end
    checks++;
    if (m_out_data !== LANE_EXP) begin
      failures++; $display("FAIL lane_data got=%h exp=%h", m_out_data, LANE_EXP);
    end
    checks++;
    if (m_out_mode !== 1'b0) begin
      failures++; $display("FAIL lane_mode_frozen got=%b exp=0", m_out_mode);
    end
    m_drain();
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    int lat;
    m_accept(1'b0, LANE_IN, ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b1) begin
      failures++; $display("FAIL midrst_busy_before got=%b exp=1", m_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_out_valid !== 1'b0 || m_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got valid=%b busy=%b exp valid=0 busy=0", m_out_valid, m_busy);
    end
    checks++;
    if (m_out_data !== 128'h0) begin
      failures++; $display("FAIL midrst_out_data got=%h exp=0", m_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_no_partial got=%b exp=0", m_out_valid);
    end
    m_accept(1'b0, {16{8'h53}}, ok);
    m_wait_valid(lat);
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL midrst_latency got=%0d exp=4", lat);
    end
    checks++;
    if (m_out_data !== {16{8'hED}}) begin
      failures++; $display("FAIL midrst_data got=%h exp=%h", m_out_data, {16{8'hED}});
    end
    m_drain();
  endtask

  task automatic test_sweep(input int k, input int lanes, input int ports);
    logic [127:0] w, r1, r2, mask;
    int lat1, lat2;
    int steps;
    steps = lanes / ports;
    mask  = (lanes == 16) ? {128{1'b1}} : ((128'h1 << (8 * lanes)) - 128'h1);
    for (int base = 0; base < 256; base += lanes) begin
      w = '0;
      for (int i = 0; i < lanes; i++) w[8*i +: 8] = 8'(base + i);
      sv_run(k, 1'b1, w, r1, lat1);
      sv_run(k, 1'b0, r1 & mask, r2, lat2);
      checks++;
      if ((r2 & mask) !== w) begin
        failures++;
        $display("FAIL sweep%0d_roundtrip base=%0d got=%h exp=%h", k, base, r2 & mask, w);
      end
      checks++;
      if (lat1 != steps || lat2 != steps) begin
        failures++;
        $display("FAIL sweep%0d_latency got=%0d/%0d exp=%0d", k, lat1, lat2, steps);
      end
    end
  endtask

`ifdef SBOX_ROUNDTRIP_CHECK_EN
  task automatic test_roundtrip_err();
    bit ok;
    int lat;
    force dut.lut_res[7:0] = 8'h64;
    m_accept(1'b0, 128'h0, ok);
    m_wait_valid(lat);
    checks++;
    if (m_out_err !== 1'b1) begin
      failures++; $display("FAIL rt_err_set got=%b exp=1", m_out_err);
    end
    m_drain();
    release dut.lut_res[7:0];
    m_accept(1'b0, 128'h0, ok);
    m_wait_valid(lat);
    checks++;
    if (m_out_err !== 1'b0) begin
      failures++; $display("FAIL rt_err_clear got=%b exp=0", m_out_err);
    end
    checks++;
    if (m_out_data !== {16{8'h63}}) begin
      failures++; $display("FAIL rt_clean_data got=%h exp=%h", m_out_data, {16{8'h63}});
    end
    m_drain();
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    m_in_valid   = 1'b0;
    m_in_mode    = 1'b0;
    m_in_data    = '0;
    m_out_ready  = 1'b0;
    sv_in_valid  = '0;
    sv_in_mode   = 1'b0;
    sv_in_data   = '0;
    sv_out_ready = 1'b1;
    test_reset();
    test_forward_backpressure();
    test_lane_map();
    test_reset_mid_busy();
    test_sweep(0, 4, 4);
    test_sweep(1, 4, 1);
    test_sweep(2, 16, 16);
`ifdef SBOX_ROUNDTRIP_CHECK_EN
    test_roundtrip_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
